// File: rtl/bp_axil_nbf_streamer.sv
// AXI-lite write-to-NBF transmitter: each accepted write becomes one NBF packet
// streamed out low flit first; reads return the number of packets emitted.
module bp_axil_nbf_streamer #(
  parameter int          stream_data_width_p = 32,
  parameter int          nbf_opcode_width_p  = 8,
  parameter int          nbf_addr_width_p    = 40,
  parameter int          nbf_data_width_p    = 64,
  parameter int          s_axil_addr_width_p = 32,
  parameter int          s_axil_data_width_p = 64,
  parameter logic [31:0] finish_addr_p       = 32'h0010_0000
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [s_axil_addr_width_p-1:0]   s_axil_awaddr_i,
  input  logic [2:0]                       s_axil_awprot_i,
  input  logic                             s_axil_awvalid_i,
  output logic                             s_axil_awready_o,
  input  logic [s_axil_data_width_p-1:0]   s_axil_wdata_i,
  input  logic [s_axil_data_width_p/8-1:0] s_axil_wstrb_i,
  input  logic                             s_axil_wvalid_i,
  output logic                             s_axil_wready_o,
  output logic [1:0]                       s_axil_bresp_o,
  output logic                             s_axil_bvalid_o,
  input  logic                             s_axil_bready_i,
  input  logic [s_axil_addr_width_p-1:0]   s_axil_araddr_i,
  input  logic [2:0]                       s_axil_arprot_i,
  input  logic                             s_axil_arvalid_i,
  output logic                             s_axil_arready_o,
  output logic [s_axil_data_width_p-1:0]   s_axil_rdata_o,
  output logic [1:0]                       s_axil_rresp_o,
  output logic                             s_axil_rvalid_o,
  input  logic                             s_axil_rready_i,
  output logic                             stream_v_o,
  output logic [stream_data_width_p-1:0]   stream_data_o,
  input  logic                             stream_ready_i
);

  localparam int A        = s_axil_addr_width_p;
  localparam int D        = s_axil_data_width_p;
  localparam int S        = s_axil_data_width_p / 8;
  localparam int W        = stream_data_width_p;
  localparam int NbfW     = nbf_opcode_width_p + nbf_addr_width_p + nbf_data_width_p;
  localparam int NumFlits = (NbfW + W - 1) / W;
  localparam int PktW     = NumFlits * W;
  localparam int CntW     = (NumFlits > 1) ? $clog2(NumFlits) : 1;

  typedef enum logic [1:0] {IDLE, SEND, RESP} state_e;

  state_e                state_q, state_d;
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [A-1:0]          awaddr_q, awaddr_d;
  logic [D-1:0]          wdata_q, wdata_d;
  logic [S-1:0]          wstrb_q, wstrb_d;
  logic [PktW-1:0]       pkt_q, pkt_d;
  logic [CntW-1:0]       flit_cnt_q, flit_cnt_d;
  logic [D-1:0]          pkt_count_q, pkt_count_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q;
  logic [D-1:0]          rdata_q;
  logic                  aw_hs, w_hs, flit_last;
  logic [A-1:0]          aw_addr_cur;
  logic [D-1:0]          w_data_cur;
  logic [S-1:0]          w_strb_cur;
  logic [PktW:0]         pkt_build;
  logic                  unused_w;

  // Returns {error, padded packet}; error is set for strobes that map to no NBF op.
  function automatic logic [PktW:0] build_pkt(input logic [A-1:0] addr,
                                              input logic [D-1:0] data,
                                              input logic [S-1:0] strb);
    logic [nbf_addr_width_p-1:0]   a_ext;
    logic [nbf_opcode_width_p-1:0] op;
    logic [nbf_addr_width_p-1:0]   pa;
    logic [nbf_data_width_p-1:0]   pd;
    logic                          err;
    a_ext = nbf_addr_width_p'(addr);
    op    = '0;
    pa    = '0;
    pd    = '0;
    err   = 1'b0;
    if (addr == A'(finish_addr_p)) begin
      op = nbf_opcode_width_p'(8'hFF);
    end else if (strb == S'(8'hFF)) begin
      op = nbf_opcode_width_p'(3);
      pa = {a_ext[nbf_addr_width_p-1:3], 3'b000};
      pd = nbf_data_width_p'(data);
    end else if (strb == S'(8'h0F)) begin
      op = nbf_opcode_width_p'(2);
      pa = {a_ext[nbf_addr_width_p-1:3], 3'b000};
      pd = nbf_data_width_p'(data[D/2-1:0]);
    end else if (strb == S'(8'hF0)) begin
      op = nbf_opcode_width_p'(2);
      pa = {a_ext[nbf_addr_width_p-1:3], 3'b100};
      pd = nbf_data_width_p'(data[D-1:D/2]);
    end else begin
      err = 1'b1;
    end
    return {err, PktW'({op, pa, pd})};
  endfunction

  assign unused_w = ^{s_axil_awprot_i, s_axil_arprot_i, s_axil_araddr_i};

  assign s_axil_awready_o = reset_n_i & (state_q == IDLE) & ~aw_held_q;
  assign s_axil_wready_o  = reset_n_i & (state_q == IDLE) & ~w_held_q;
  assign s_axil_arready_o = reset_n_i & ~rvalid_q;
  assign aw_hs            = s_axil_awvalid_i & s_axil_awready_o;
  assign w_hs             = s_axil_wvalid_i & s_axil_wready_o;

  // A channel arriving in the same cycle as its partner is used directly so
  // the packet loads on the completing handshake.
  assign aw_addr_cur = aw_held_q ? awaddr_q : s_axil_awaddr_i;
  assign w_data_cur  = w_held_q  ? wdata_q  : s_axil_wdata_i;
  assign w_strb_cur  = w_held_q  ? wstrb_q  : s_axil_wstrb_i;
  assign pkt_build   = build_pkt(aw_addr_cur, w_data_cur, w_strb_cur);
  assign flit_last   = (flit_cnt_q == CntW'(NumFlits - 1));

  assign stream_v_o      = (state_q == SEND);
  assign stream_data_o   = stream_v_o ? pkt_q[flit_cnt_q*W +: W] : '0;
  assign s_axil_bvalid_o = (state_q == RESP);
  assign s_axil_bresp_o  = bresp_q;
  assign s_axil_rvalid_o = rvalid_q;
  assign s_axil_rdata_o  = rdata_q;
  assign s_axil_rresp_o  = 2'b00;

  always_comb begin
    state_d     = state_q;
    aw_held_d   = aw_held_q;
    w_held_d    = w_held_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    pkt_d       = pkt_q;
    flit_cnt_d  = flit_cnt_q;
    pkt_count_d = pkt_count_q;
    bresp_d     = bresp_q;
    unique case (state_q)
      IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_axil_awaddr_i;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = s_axil_wdata_i;
          wstrb_d  = s_axil_wstrb_i;
        end
        if (aw_held_d && w_held_d) begin
          pkt_d      = pkt_build[PktW-1:0];
          flit_cnt_d = '0;
          if (pkt_build[PktW]) begin
            bresp_d = 2'b10;
            state_d = RESP;
          end else begin
            state_d = SEND;
          end
        end
      end
      SEND: begin
        if (stream_ready_i) begin
          if (flit_last) begin
            flit_cnt_d  = '0;
            pkt_count_d = pkt_count_q + D'(1);
            bresp_d     = 2'b00;
            state_d     = RESP;
          end else begin
            flit_cnt_d = flit_cnt_q + CntW'(1);
          end
        end
      end
      RESP: begin
        if (s_axil_bready_i) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      pkt_q       <= '0;
      flit_cnt_q  <= '0;
      pkt_count_q <= '0;
      bresp_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      aw_held_q   <= aw_held_d;
      w_held_q    <= w_held_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      pkt_q       <= pkt_d;
      flit_cnt_q  <= flit_cnt_d;
      pkt_count_q <= pkt_count_d;
      bresp_q     <= bresp_d;
    end
  end

  // Read side samples the count before any same-cycle increment lands.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (s_axil_arvalid_i && s_axil_arready_o) begin
      rvalid_q <= 1'b1;
      rdata_q  <= pkt_count_q;
    end else if (s_axil_rready_i) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bp_axil_nbf_streamer.sv
// Directed bench for bp_axil_nbf_streamer with a packet-level model of the
// expected flit stream and emitted-packet count.
module tb_bp_axil_nbf_streamer;

  localparam logic [31:0] FIN = 32'h0010_0000;

  typedef struct packed {
    logic [31:0] d;
    logic        last;
  } flit_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic        stream_v;
  logic [31:0] stream_data;
  logic        stream_ready;

  int          n_chk = 0;
  int          n_fail = 0;
  int          hs_cnt = 0;
  logic [63:0] exp_pkts = '0;
  flit_t       exp_q[$];
  logic [31:0] got_q[$];

  always #5 clk = ~clk;

  bp_axil_nbf_streamer dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .s_axil_awaddr_i (awaddr),
    .s_axil_awprot_i (awprot),
    .s_axil_awvalid_i(awvalid),
    .s_axil_awready_o(awready),
    .s_axil_wdata_i  (wdata),
    .s_axil_wstrb_i  (wstrb),
    .s_axil_wvalid_i (wvalid),
    .s_axil_wready_o (wready),
    .s_axil_bresp_o  (bresp),
    .s_axil_bvalid_o (bvalid),
    .s_axil_bready_i (bready),
    .s_axil_araddr_i (araddr),
    .s_axil_arprot_i (arprot),
    .s_axil_arvalid_i(arvalid),
    .s_axil_arready_o(arready),
    .s_axil_rdata_o  (rdata),
    .s_axil_rresp_o  (rresp),
    .s_axil_rvalid_o (rvalid),
    .s_axil_rready_i (rready),
    .stream_v_o      (stream_v),
    .stream_data_o   (stream_data),
    .stream_ready_i  (stream_ready)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // {error, 16'h0 pad, opcode, addr, data}
  function automatic logic [128:0] model_pkt(input logic [31:0] a, input logic [63:0] d,
                                             input logic [7:0] s);
    logic [7:0]  op;
    logic [39:0] pa;
    logic [63:0] pd;
    logic        err;
    pa  = {8'h0, a} & ~40'h7;
    err = 1'b0;
    op  = 8'h0;
    pd  = 64'h0;
    if (a == FIN) begin
      op = 8'hFF; pa = 40'h0;
    end else if (s == 8'hFF) begin
      op = 8'd3; pd = d;
    end else if (s == 8'h0F) begin
      op = 8'd2; pd = {32'h0, d[31:0]};
    end else if (s == 8'hF0) begin
      op = 8'd2; pa = pa + 40'd4; pd = {32'h0, d[63:32]};
    end else begin
      err = 1'b1; pa = 40'h0;
    end
    return {err, 16'h0, op, pa, pd};
  endfunction

  task automatic push_model(input logic [128:0] m);
    for (int k = 0; k < 4; k++) exp_q.push_back(flit_t'{d: m[k*32 +: 32], last: (k == 3)});
  endtask

  task automatic compare_loop();
    flit_t       f;
    logic        prev_stall;
    logic [31:0] prev_d;
    prev_stall = 1'b0;
    prev_d     = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        exp_q.delete();
        exp_pkts   = '0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stream_hold_v", stream_v, 1);
          chk("stream_hold_d", stream_data, prev_d);
        end
        if (stream_v && stream_ready) begin
          hs_cnt++;
          got_q.push_back(stream_data);
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL stream_extra: got flit %h, none expected", stream_data);
          end else begin
            f = exp_q.pop_front();
            chk("stream_flit", stream_data, f.d);
            if (f.last) exp_pkts++;
          end
        end
        prev_stall = stream_v && !stream_ready;
        prev_d     = stream_data;
      end
    end
  endtask

  // w_lead = cycles W is presented before AW. chk_lat assumes stream_ready stays 1.
  task automatic axi_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                           input int w_lead, input bit chk_lat, input string nm);
    logic [128:0] m;
    bit           aw_done, w_done;
    int           n;
    m = model_pkt(a, d, s);
    @(posedge clk); #1;
    wdata = d; wstrb = s; wvalid = 1'b1; awaddr = a; awvalid = (w_lead == 0);
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done)) begin
      @(negedge clk);
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      @(posedge clk); #1;
      n++;
      if (aw_done) awvalid = 1'b0;
      if (w_done) wvalid = 1'b0;
      if (n == w_lead && !aw_done) awvalid = 1'b1;
      if (n > 40) begin
        chk({nm, "_accept_timeout"}, 0, 1);
        awvalid = 1'b0; wvalid = 1'b0;
        return;
      end
    end
    if (!m[128]) push_model(m);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (chk_lat && n == 1) chk({nm, "_v_t+1"}, stream_v, !m[128]);
      if (bvalid) break;
      if (n > 60) begin
        chk({nm, "_bvalid_timeout"}, 0, 1);
        return;
      end
    end
    if (chk_lat) chk({nm, "_b_latency"}, n, m[128] ? 1 : 5);
    chk({nm, "_bresp"}, bresp, m[128] ? 2'b10 : 2'b00);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    chk({nm, "_bvalid_clr"}, bvalid, 0);
    chk({nm, "_awready_back"}, awready, 1);
  endtask

  task automatic axi_read(input logic [63:0] lit, input string nm);
    int n;
    @(posedge clk); #1;
    arvalid = 1'b1; araddr = 32'hDEAD_BEE0;
    @(negedge clk);
    chk({nm, "_arready"}, arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(negedge clk);
    chk({nm, "_rvalid"}, rvalid, 1);
    chk({nm, "_rdata_model"}, rdata, exp_pkts);
    chk({nm, "_rdata_lit"}, rdata, lit);
    chk({nm, "_rresp"}, rresp, 2'b00);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    @(negedge clk);
    chk({nm, "_rvalid_clr"}, rvalid, 0);
  endtask

  task automatic chk_got(input string nm, input logic [31:0] f0, input logic [31:0] f1,
                         input logic [31:0] f2, input logic [31:0] f3);
    logic [31:0] lit[4];
    lit = '{f0, f1, f2, f3};
    chk({nm, "_flit_count"}, got_q.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < got_q.size()) chk($sformatf("%s_flit%0d", nm, k), got_q[k], lit[k]);
  endtask

  initial begin
    int   h0;
    logic pat[7];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    reset_n = 1'b0; awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
    wvalid = 1'b0; bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    stream_ready = 1'b1;
    fork
      compare_loop();
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_stream_v", stream_v, 0);
    chk("rst_stream_data", stream_data, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_awready", awready, 1);
    chk("rel_wready", wready, 1);
    chk("rel_arready", arready, 1);
    chk("rel_stream_v", stream_v, 0);

    // Bad strobe: error response, no packet
    axi_write(32'h0000_0100, 64'h0123_4567_89AB_CDEF, 8'h3C, 0, 1, "err");
    axi_read(64'd0, "rd_after_err");

    // Finish packet (strobe ignored)
    got_q.delete();
    axi_write(FIN, 64'hDEAD_BEEF_0000_1111, 8'h3C, 0, 1, "fin");
    chk_got("fin", 32'h0, 32'h0, 32'h0, 32'h0000_FF00);
    axi_read(64'd1, "rd_after_fin");

    // Full 8-byte write, AW and W together
    got_q.delete();
    axi_write(32'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0, 1, "w8");
    chk_got("w8", 32'h5566_7788, 32'h1122_3344, 32'h8000_0010, 32'h0000_0300);

    // Upper-half 4-byte write, W three cycles ahead of AW
    got_q.delete();
    axi_write(32'h8000_0004, 64'hAABB_CCDD_0000_0000, 8'hF0, 3, 1, "w4hi");
    chk_got("w4hi", 32'hAABB_CCDD, 32'h0, 32'h8000_0004, 32'h0000_0200);

    // Lower-half 4-byte write, AW ahead of W is not possible here, use model only
    axi_write(32'h0000_200C, 64'hFFFF_EEEE_1234_5678, 8'h0F, 0, 1, "w4lo");
    axi_read(64'd4, "rd_after_4");

    // Backpressure pattern during SEND
    stream_ready = 1'b0;
    h0 = hs_cnt;
    fork
      axi_write(32'h0000_1000, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 0, "stall");
      begin
        for (int i = 0; i < 20; i++) begin
          @(posedge clk); #1;
          if (stream_v) break;
        end
        for (int i = 0; i < 7; i++) begin
          stream_ready = pat[i];
          @(posedge clk); #1;
        end
        stream_ready = 1'b1;
      end
    join
    chk("stall_handshakes", hs_cnt - h0, 4);
    chk("stall_queue_empty", exp_q.size(), 0);

    // Reset in the middle of a packet
    stream_ready = 1'b0;
    @(posedge clk); #1;
    awaddr = 32'h0000_3000; wdata = 64'h5555_6666_7777_8888; wstrb = 8'hFF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    push_model(model_pkt(32'h0000_3000, 64'h5555_6666_7777_8888, 8'hFF));
    stream_ready = 1'b1;
    h0 = hs_cnt;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_v_drop", stream_v, 0);
    @(negedge clk);
    chk("midrst_flits_before", hs_cnt - h0, 2);
    chk("midrst_stream_v", stream_v, 0);
    chk("midrst_stream_data", stream_data, 0);
    chk("midrst_bvalid", bvalid, 0);
    chk("midrst_awready", awready, 0);
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_rel_awready", awready, 1);
    chk("midrst_rel_stream_v", stream_v, 0);
    axi_write(32'h0000_4000, 64'h0A0B_0C0D_0E0F_1011, 8'hFF, 0, 1, "post1");
    axi_write(32'h0000_4008, 64'h2021_2223_2425_2627, 8'hF0, 1, 1, "post2");
    axi_read(64'd2, "rd_after_midrst");

    repeat (2) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
